// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encodings, scheduler FSM states and MDU latency default.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  localparam int MDU_LAT_DEF = 32;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_ctrl_if #(parameter int RA_W = 5);
  logic [RA_W-1:0] ra1, ra2, ex_wra, mem_wra, wb_wra;
  logic use1, use2, ex_reg_we, ex_load, mem_reg_we, wb_reg_we, mdu_start, br_taken;
  logic stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_done;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] mdu_cnt;
  modport master (
    output ra1, ra2, use1, use2, ex_reg_we, ex_wra, ex_load, mem_reg_we, mem_wra,
           wb_reg_we, wb_wra, mdu_start, br_taken,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, mdu_busy, mdu_done, mdu_cnt
  );
  modport slave (
    input  ra1, ra2, use1, use2, ex_reg_we, ex_wra, ex_load, mem_reg_we, mem_wra,
           wb_reg_we, wb_wra, mdu_start, br_taken,
    output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, mdu_busy, mdu_done, mdu_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: priority forwarding select (EX > MEM > WB > regfile) for one decode operand.
module fwd_sel
  import hazard_pkg::*;
#(parameter int RA_W = 5) (
  input  logic [RA_W-1:0] src,
  input  logic            en,
  input  logic            ex_we,
  input  logic [RA_W-1:0] ex_wra,
  input  logic            ex_load,
  input  logic            mem_we,
  input  logic [RA_W-1:0] mem_wra,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_wra,
  output logic [1:0]      sel
);
  logic live, ex_hit, mem_hit, wb_hit;
  always_comb begin
    live    = en && src != '0;
    // a load in EX has no data yet; that case is stalled, not forwarded
    ex_hit  = live && ex_we && ex_wra == src && !ex_load;
    mem_hit = live && mem_we && mem_wra == src;
    wb_hit  = live && wb_we && wb_wra == src;
    sel     = ex_hit ? FWD_EX : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage core plus fixed-latency MDU sequencing.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int RA_W    = 5
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic load_use, idle, run, go;
  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src(bus.ra1), .en(bus.use1),
    .ex_we(bus.ex_reg_we), .ex_wra(bus.ex_wra), .ex_load(bus.ex_load),
    .mem_we(bus.mem_reg_we), .mem_wra(bus.mem_wra),
    .wb_we(bus.wb_reg_we), .wb_wra(bus.wb_wra),
    .sel(bus.fwd_a)
  );
  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src(bus.ra2), .en(bus.use2),
    .ex_we(bus.ex_reg_we), .ex_wra(bus.ex_wra), .ex_load(bus.ex_load),
    .mem_we(bus.mem_reg_we), .mem_wra(bus.mem_wra),
    .wb_we(bus.wb_reg_we), .wb_wra(bus.wb_wra),
    .sel(bus.fwd_b)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    idle      = state == IDLE;
    run       = state == MDU_RUN;
    load_use  = bus.ex_load && bus.ex_reg_we && bus.ex_wra != '0 &&
                ((bus.use1 && bus.ra1 == bus.ex_wra) || (bus.use2 && bus.ra2 == bus.ex_wra));
    go        = idle && bus.mdu_start && !load_use && !bus.br_taken;
    // MDU_DONE always falls back to IDLE so a held start cannot retrigger
    state_nxt = idle ? (go ? MDU_RUN : IDLE) :
                run  ? (bus.br_taken ? IDLE : cnt == 8'd0 ? MDU_DONE : MDU_RUN) : IDLE;
    cnt_nxt   = go ? 8'(MDU_LAT - 1) :
                (run && !bus.br_taken && cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
  end
  always_comb begin
    bus.stall_f  = !bus.br_taken && ((idle && load_use) || run);
    bus.stall_d  = bus.stall_f;
    bus.flush_d  = bus.br_taken;
    bus.flush_e  = bus.br_taken || bus.stall_f;
    bus.mdu_busy = run;
    bus.mdu_done = state == MDU_DONE;
    bus.mdu_cnt  = cnt;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors feed an expectation queue; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  hazard_ctrl_if #(.RA_W(5)) bus ();
  hazard_ctrl #(.MDU_LAT(4), .RA_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    string      name;
    logic [18:0] val;
  } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  function automatic logic [18:0] mk(input logic sf, sd, fd, fe, input logic [1:0] fa, fb,
                                     input logic busy, done, input logic [7:0] cnt);
    return {sf, sd, fd, fe, fa, fb, busy, done, cnt};
  endfunction
  task automatic clr();
    bus.ra1 = '0; bus.ra2 = '0; bus.use1 = 0; bus.use2 = 0;
    bus.ex_reg_we = 0; bus.ex_wra = '0; bus.ex_load = 0;
    bus.mem_reg_we = 0; bus.mem_wra = '0; bus.wb_reg_we = 0; bus.wb_wra = '0;
    bus.mdu_start = 0; bus.br_taken = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask
  task automatic expect_out(input string nm, input logic [18:0] v);
    exp_t e;
    e.name = nm;
    e.val = v;
    q.push_back(e);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        logic [18:0] act;
        e = q.pop_front();
        act = {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.fwd_a, bus.fwd_b,
               bus.mdu_busy, bus.mdu_done, bus.mdu_cnt};
        n_tests++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h", e.name, act, e.val);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    clr();
    tick(); expect_out("in_reset", '0);
    tick(); rst = 0; expect_out("idle_after_reset", '0);
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 8; bus.use1 = 1; bus.ra1 = 8;
    expect_out("fwd_ex", mk(0,0,0,0,2'b01,2'b00,0,0,8'd0));
    tick(); bus.mem_reg_we = 1; bus.mem_wra = 8; bus.use1 = 1; bus.ra1 = 8;
    expect_out("fwd_mem", mk(0,0,0,0,2'b10,2'b00,0,0,8'd0));
    tick(); bus.wb_reg_we = 1; bus.wb_wra = 8; bus.use1 = 1; bus.ra1 = 8;
    expect_out("fwd_wb", mk(0,0,0,0,2'b11,2'b00,0,0,8'd0));
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 8; bus.mem_reg_we = 1; bus.mem_wra = 8;
    bus.use1 = 1; bus.ra1 = 8;
    expect_out("fwd_ex_over_mem", mk(0,0,0,0,2'b01,2'b00,0,0,8'd0));
    tick(); bus.mem_reg_we = 1; bus.mem_wra = 7; bus.wb_reg_we = 1; bus.wb_wra = 7;
    bus.use2 = 1; bus.ra2 = 7;
    expect_out("fwdb_mem_over_wb", mk(0,0,0,0,2'b00,2'b10,0,0,8'd0));
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 8; bus.use1 = 0; bus.ra1 = 8;
    expect_out("no_use_no_fwd", '0);
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 0; bus.use1 = 1; bus.ra1 = 0;
    expect_out("reg0_no_fwd", '0);
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 0; bus.ex_load = 1; bus.use1 = 1; bus.ra1 = 0;
    expect_out("reg0_load_no_stall", '0);
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 9; bus.ex_load = 1; bus.use2 = 1; bus.ra2 = 9;
    expect_out("load_use_stall", mk(1,1,0,1,2'b00,2'b00,0,0,8'd0));
    tick(); bus.mem_reg_we = 1; bus.mem_wra = 9; bus.use2 = 1; bus.ra2 = 9;
    expect_out("load_in_mem_fwd", mk(0,0,0,0,2'b00,2'b10,0,0,8'd0));
    tick(); bus.ex_reg_we = 1; bus.ex_wra = 9; bus.ex_load = 1; bus.use2 = 1; bus.ra2 = 9;
    bus.br_taken = 1;
    expect_out("branch_over_load_use", mk(0,0,1,1,2'b00,2'b00,0,0,8'd0));
    tick(); bus.mdu_start = 1; bus.br_taken = 1;
    expect_out("branch_over_mdu_start", mk(0,0,1,1,2'b00,2'b00,0,0,8'd0));
    tick(); expect_out("no_mdu_after_branch", '0);
    tick(); bus.mdu_start = 1; bus.ex_reg_we = 1; bus.ex_wra = 3; bus.ex_load = 1;
    bus.use1 = 1; bus.ra1 = 3;
    expect_out("load_use_blocks_mdu", mk(1,1,0,1,2'b00,2'b00,0,0,8'd0));
    tick(); expect_out("still_idle", '0);
    tick(); bus.mdu_start = 1; expect_out("mdu_start_idle", '0);
    tick(); bus.mdu_start = 1; expect_out("mdu_run3", mk(1,1,0,1,2'b00,2'b00,1,0,8'd3));
    tick(); bus.mdu_start = 1; bus.mem_reg_we = 1; bus.mem_wra = 8; bus.use1 = 1; bus.ra1 = 8;
    expect_out("mdu_run2_fwd", mk(1,1,0,1,2'b10,2'b00,1,0,8'd2));
    tick(); bus.mdu_start = 1; expect_out("mdu_run1", mk(1,1,0,1,2'b00,2'b00,1,0,8'd1));
    tick(); bus.mdu_start = 1; expect_out("mdu_run0", mk(1,1,0,1,2'b00,2'b00,1,0,8'd0));
    tick(); bus.mdu_start = 1; expect_out("mdu_done", mk(0,0,0,0,2'b00,2'b00,0,1,8'd0));
    tick(); expect_out("idle_no_retrigger", '0);
    tick(); expect_out("idle_again", '0);
    tick(); bus.mdu_start = 1; expect_out("abort_start", '0);
    tick(); expect_out("abort_run3", mk(1,1,0,1,2'b00,2'b00,1,0,8'd3));
    tick(); bus.br_taken = 1; expect_out("abort_branch", mk(0,0,1,1,2'b00,2'b00,1,0,8'd2));
    tick(); expect_out("abort_idle_no_done", '0);
    tick(); bus.mdu_start = 1; expect_out("rst_start", '0);
    tick(); expect_out("rst_run3", mk(1,1,0,1,2'b00,2'b00,1,0,8'd3));
    tick(); rst = 1; expect_out("async_reset", '0);
    tick(); rst = 0; expect_out("after_release", '0);
    tick(); expect_out("no_pulse_after_release", '0);
    tick(); bus.mdu_start = 1; expect_out("fresh_start", '0);
    tick(); expect_out("fresh_run3", mk(1,1,0,1,2'b00,2'b00,1,0,8'd3));
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS-style core. It sits beside the decode stage and drives the stall and flush enables of the IF/DEC/EX pipeline registers.
- It produces the rd1/rd2 forwarding selects for the decode operand muxes.
- It sequences a multi-cycle MUL/DIV unit (MDU) by freezing the front end for a fixed latency.
- Load-use and branch hazards are resolved combinationally. MDU occupancy is tracked by a small registered FSM plus a down-counter.

Parameters:
- MDU_LAT, 32, cycles the MDU needs from start to result valid (legal range 2..255).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous active-high reset
- i_ra1  in  RA_W  DEC source register 1 (rs)
- i_ra2  in  RA_W  DEC source register 2 (rt)
- i_use1  in  1  DEC instruction reads ra1
- i_use2  in  1  DEC instruction reads ra2
- i_exRegWe  in  1  EX-stage instruction writes the register file
- i_exWRA  in  RA_W  EX-stage write address
- i_exLoad  in  1  EX-stage instruction is a load
- i_memRegWe  in  1  MEM-stage write enable
- i_memWRA  in  RA_W  MEM-stage write address
- i_wbRegWe  in  1  WB-stage write enable
- i_wbWRA  in  RA_W  WB-stage write address
- i_mduStart  in  1  DEC holds an MDU instruction
- i_brTaken  in  1  EX resolved a taken branch or jump
- o_stallF  out  1  hold PC/IF register
- o_stallD  out  1  hold DEC register
- o_flushD  out  1  clear DEC register (insert NOP)
- o_flushE  out  1  clear EX register (bubble)
- o_fwdA  out  2  rd1 source: 00 regfile, 01 EX aluOut, 10 MEM data, 11 WB result
- o_fwdB  out  2  rd2 source, same encoding
- o_mduBusy  out  1  MDU running
- o_mduDone  out  1  one-cycle pulse, MDU result valid
- o_mduCnt  out  8  remaining MDU cycles (debug)

Behaviour:
- Reset: state IDLE, counter 0. With all inputs 0, every output is 0.
- Forwarding (combinational, per operand):
  - A match requires the use bit set, the stage regWe set, stage WRA == source register, and source register != 0.
  - Priority is EX > MEM > WB > regfile.
  - An EX match is suppressed when i_exLoad = 1; that case is a load-use hazard instead.
- Load-use (IDLE only):
  - Condition: i_exLoad & i_exRegWe & i_exWRA != 0 & (ra1 match with use1 | ra2 match with use2).
  - Response, same cycle: stallF = stallD = 1, flushE = 1.
  - Exactly one bubble. The next cycle the load is in MEM and MEM forwarding applies.
- Branch:
  - i_brTaken → flushD = 1 and flushE = 1 in the same cycle.
  - stallF = stallD = 0, so the redirect is taken.
  - i_brTaken overrides load-use and MDU start.
- FSM states: IDLE, MDU_RUN, MDU_DONE.
  - IDLE → MDU_RUN when i_mduStart & !loadUse & !i_brTaken. Counter loads MDU_LAT-1.
  - MDU_RUN:
    - Outputs: stallF = stallD = 1, flushE = 1, mduBusy = 1.
    - Counter decrements each cycle. At counter == 0 the next state is MDU_DONE.
    - Forward selects are still computed normally.
  - MDU_DONE:
    - Outputs: mduDone = 1, stalls = 0, flushE = 0.
    - The MDU instruction advances into EX.
    - Always returns to IDLE. A still-high i_mduStart in this cycle does not retrigger.
  - i_brTaken in MDU_RUN (defensive): abort to IDLE, counter → 0, no mduDone, flushD = flushE = 1.
- MDU stall length: total stall cycles = MDU_LAT, counting MDU_RUN from entry to exit.
- o_mduCnt reflects the counter register. It is 0 outside MDU_RUN.
- Reset asserted mid-MDU: state → IDLE immediately (async), busy/done drop, no pulse on release.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants
  - the FSM state enum (2 bits)
  - the MDU_LAT default
- Sub-module fwd_sel: the combinational priority selector for one operand. It is instantiated twice, for rd1 and rd2.

Test Plan:
- EX writes $8 (no load), DEC reads rs=$8 → fwdA=01, no stall. Same with MEM only → 10. With WB only → 11. With EX and MEM both $8 → 01.
- Source $0 while EX writes $0 with regWe=1 → fwdA=00, no stall.
- lw $9 in EX, DEC reads rt=$9 → one cycle stallF=stallD=flushE=1. Next cycle (load in MEM) → fwdB=10, stalls 0.
- Load-use condition plus i_brTaken in the same cycle → stalls 0, flushD=flushE=1.
- MDU_LAT=4, i_mduStart pulse held: stall for exactly 4 cycles with o_mduCnt 3,2,1,0. Then mduDone=1 for 1 cycle, then IDLE with no retrigger.
- rst pulsed in the 2nd MDU_RUN cycle → all outputs 0 asynchronously. After release, idle until a fresh i_mduStart.
